wb_seq_ctrl: RTL and testbench
==============================

Name: wb_seq_ctrl

Overview:
- Write-back stage controller for the 16-bit Thumb-subset core; successor to the single-cycle write-back decoder.
- Decodes the instruction in WB and drives the register-file write address and enable.
- Adds a sequencer for multi-register loads (POP, LDMIA): one register write per cycle, with a busy signal that holds the upstream pipeline.
- Generalised in register count and special register indices.

Parameters:
NREGS, 16, number of architectural registers
ADDR_W, $clog2(NREGS), register address width
LIST_W, 8, width of the low-register list field in POP/LDMIA
SP_IDX, 13, stack pointer register index
PC_IDX, 15, program counter register index

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
i_ir_wb  in  16  instruction in WB stage
i_valid  in  1  i_ir_wb is valid this cycle
i_stall  in  1  pipeline stall; freezes all state
o_we  out  1  register-file write enable
o_waddr  out  ADDR_W  register-file write address
o_busy  out  1  sequencer holds further writes; upstream must not advance
o_wcount  out  ADDR_W+1  registers written by the current multi-register op (incremented per write)
o_base_upd  out  1  current write is a base/SP update (see optional feature)

Behaviour:
- Reset: o_we=0, o_waddr=0, o_busy=0, o_wcount=0, o_base_upd=0; FSM to IDLE; remaining mask cleared.
  - Reset mid-sequence aborts the sequence; the next cycle shows reset values.
- All outputs are registered. An instruction accepted in cycle N produces its first write in cycle N+1.
- Accept condition: i_valid & !i_stall & !o_busy. While o_busy=1, i_ir_wb and i_valid are ignored.
- Single-write decode, on accept (o_we=1 next cycle):
  - ir[15:11]=00011 ADD/SUB reg/imm3: rd=ir[2:0]
  - ir[15:13]=000 with ir[12:11]!=11 (shift imm): rd=ir[2:0]
  - ir[15:13]=001 (MOV/ADD/SUB imm8): rd=ir[10:8]; CMP (ir[12:11]=01) gives no write
  - ir[15:8]=01000110 MOV hi: rd={ir[7],ir[2:0]}
  - ir[15:11]=01101 LDR imm: rd=ir[2:0]
  - ir[15:8]=10110000 ADD/SUB SP imm7: rd=SP_IDX
  - Addresses are zero-extended to ADDR_W.
- Multi-write decode:
  - POP, ir[15:9]=1011110: mask = {P=ir[8] -> PC_IDX, ir[7:0]}.
  - LDMIA, ir[15:11]=11001: mask = ir[7:0].
- Anything else, including an unaccepted cycle: o_we=0, o_waddr holds its previous value.
- FSM states IDLE and SEQ:
  - IDLE, accepted multi-write with mask≠0: emit the lowest set bit next cycle and clear it from the mask. o_wcount=1. If the mask is still non-zero, go to SEQ with o_busy=1.
  - Empty mask (POP/LDMIA with list=0, P=0): no write, o_busy stays 0, o_wcount=0.
  - SEQ, !i_stall: emit the next lowest set bit (low list bits ascending, then PC_IDX last) and increment o_wcount. When the mask empties, o_busy=0 on that same final write cycle and the FSM returns to IDLE.
  - SEQ, i_stall: o_we=0; mask, o_waddr, o_wcount and o_busy held.
- Stall in IDLE: o_we=0, o_waddr held.
- o_wcount holds its value until the next accepted multi-write; single writes do not modify it.

Optional Feature:
- Macro: WB_BASE_UPD_EN.
- When defined, after the final list write of a POP or of an LDMIA whose Rn=ir[10:8] is not in the list, one extra cycle writes the base register with o_we=1, o_base_upd=1. The address is SP_IDX for POP and Rn for LDMIA.
  - o_busy stays 1 through the final list write and drops on the base-update cycle.
  - Empty-mask POP/LDMIA produce no base write.
- When undefined, o_base_upd is tied to 0 and no extra cycle is inserted.

Test Plan:
- ADD r3 (0x18CB) accepted at cycle 0 -> cycle 1: o_we=1, o_waddr=3, o_busy=0; CMP r1,#5 (0x2905) -> o_we=0.
- MOV r9,r2 (0x4691) -> o_waddr=9, o_we=1; ADD SP,#8 (0xB002) -> o_waddr=13.
- POP {r0,r2,pc} (0xBD05) -> writes r0, r2, r15 on cycles 1-3; o_busy=1,1,0; o_wcount=1,2,3; i_valid pulses during busy are ignored.
- POP {r1,r4} with i_stall=1 on cycle 2 -> cycle 2 o_we=0, busy held; r4 written on cycle 3.
- POP {} (0xBC00) -> no write, o_busy=0; rst asserted mid-LDMIA {r0-r7} -> all outputs 0 next cycle, sequence abandoned.
- WB_BASE_UPD_EN defined, LDMIA r5!,{r0,r1} -> r0, r1, then r5 with o_base_upd=1; with list containing r5, no base write.

Source files
------------

// File: rtl/wb_seq_ctrl.sv
// wb_seq_ctrl: write-back stage controller for the 16-bit Thumb-subset core.
// Decodes the WB instruction into a register-file write (address + enable) and
// sequences multi-register loads (POP / LDMIA) one register per cycle, raising
// o_busy to hold the upstream pipeline while the sequence is in flight.
// Optional feature macro: WB_BASE_UPD_EN -- adds a trailing base-register
// (SP for POP, Rn for LDMIA) write-back cycle flagged by o_base_upd.
module wb_seq_ctrl #(
    parameter int NREGS  = 16,
    parameter int ADDR_W = $clog2(NREGS),
    parameter int LIST_W = 8,
    parameter int SP_IDX = 13,
    parameter int PC_IDX = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       i_ir_wb,
    input  logic              i_valid,
    input  logic              i_stall,
    output logic              o_we,
    output logic [ADDR_W-1:0] o_waddr,
    output logic              o_busy,
    output logic [ADDR_W:0]   o_wcount,
    output logic              o_base_upd
);

`ifdef WB_BASE_UPD_EN
    localparam bit BASE_EN = 1'b1;
`else
    localparam bit BASE_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEQ  = 2'd1,
        BASE = 2'd2
    } state_t;

    state_t              state_q;
    logic [NREGS-1:0]    mask_q;
    logic                we_q;
    logic [ADDR_W-1:0]   waddr_q;
    logic                busy_q;
    logic [ADDR_W:0]     wcount_q;
    logic                baseUpd_q;
    logic                basePend_q;
    logic [ADDR_W-1:0]   baseAddr_q;

    logic                decWe;
    logic [ADDR_W-1:0]   decAddr;
    logic                decMulti;
    logic [NREGS-1:0]    decMask;
    logic                decBaseReq;
    logic [ADDR_W-1:0]   decBaseAddr;

    logic [NREGS-1:0]    srcMask;
    logic [ADDR_W-1:0]   lowIdx;
    logic [NREGS-1:0]    mask_d;

    // Index of the lowest set bit; ascending order puts the low list first and PC last.
    function automatic logic [ADDR_W-1:0] lowestSet(input logic [NREGS-1:0] m);
        logic [ADDR_W-1:0] idx;
        idx = '0;
        for (int i = NREGS - 1; i >= 0; i--) begin
            if (m[i]) idx = ADDR_W'(i);
        end
        return idx;
    endfunction

    // Instruction decode: single-write target, or the register mask of a multi-load.
    always_comb begin
        decWe       = 1'b0;
        decAddr     = '0;
        decMulti    = 1'b0;
        decMask     = '0;
        decBaseReq  = 1'b0;
        decBaseAddr = '0;
        if (i_ir_wb[15:13] == 3'b000) begin
            // ADD/SUB reg/imm3 and the shift-immediate group share rd=ir[2:0]
            decWe   = 1'b1;
            decAddr = ADDR_W'(i_ir_wb[2:0]);
        end else if (i_ir_wb[15:13] == 3'b001) begin
            decWe   = (i_ir_wb[12:11] != 2'b01);
            decAddr = ADDR_W'(i_ir_wb[10:8]);
        end else if (i_ir_wb[15:8] == 8'b01000110) begin
            decWe   = 1'b1;
            decAddr = ADDR_W'({i_ir_wb[7], i_ir_wb[2:0]});
        end else if (i_ir_wb[15:11] == 5'b01101) begin
            decWe   = 1'b1;
            decAddr = ADDR_W'(i_ir_wb[2:0]);
        end else if (i_ir_wb[15:8] == 8'b10110000) begin
            decWe   = 1'b1;
            decAddr = ADDR_W'(SP_IDX);
        end else if (i_ir_wb[15:9] == 7'b1011110) begin
            decMulti                 = 1'b1;
            decMask[LIST_W-1:0]      = i_ir_wb[LIST_W-1:0];
            decMask[PC_IDX]          = i_ir_wb[8];
            decBaseAddr              = ADDR_W'(SP_IDX);
            decBaseReq               = BASE_EN && (decMask != '0);
        end else if (i_ir_wb[15:11] == 5'b11001) begin
            decMulti                 = 1'b1;
            decMask[LIST_W-1:0]      = i_ir_wb[LIST_W-1:0];
            decBaseAddr              = ADDR_W'(i_ir_wb[10:8]);
            // Rn in the list means the loaded value wins; no write-back then
            decBaseReq               = BASE_EN && (decMask != '0) && !i_ir_wb[i_ir_wb[10:8]];
        end
    end

    // Pick the next register to write and the mask left after writing it.
    always_comb begin
        srcMask         = (state_q == IDLE) ? decMask : mask_q;
        lowIdx          = lowestSet(srcMask);
        mask_d          = srcMask;
        mask_d[lowIdx]  = 1'b0;
    end

    // Sequencer FSM with registered outputs; a stall freezes everything but drops o_we.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            busy_q     <= 1'b0;
            wcount_q   <= '0;
            baseUpd_q  <= 1'b0;
            basePend_q <= 1'b0;
            baseAddr_q <= '0;
        end else begin
            we_q      <= 1'b0;
            baseUpd_q <= 1'b0;
            if (!i_stall) begin
                case (state_q)
                    IDLE: begin
                        if (i_valid) begin
                            if (decWe) begin
                                we_q    <= 1'b1;
                                waddr_q <= decAddr;
                            end else if (decMulti) begin
                                if (decMask != '0) begin
                                    we_q       <= 1'b1;
                                    waddr_q    <= lowIdx;
                                    mask_q     <= mask_d;
                                    wcount_q   <= (ADDR_W + 1)'(1);
                                    basePend_q <= decBaseReq;
                                    baseAddr_q <= decBaseAddr;
                                    if (mask_d != '0) begin
                                        state_q <= SEQ;
                                        busy_q  <= 1'b1;
                                    end else if (decBaseReq) begin
                                        state_q <= BASE;
                                        busy_q  <= 1'b1;
                                    end
                                end else begin
                                    wcount_q <= '0;
                                end
                            end
                        end
                    end
                    SEQ: begin
                        we_q     <= 1'b1;
                        waddr_q  <= lowIdx;
                        mask_q   <= mask_d;
                        wcount_q <= wcount_q + (ADDR_W + 1)'(1);
                        if (mask_d == '0) begin
                            if (basePend_q) begin
                                state_q <= BASE;
                            end else begin
                                state_q <= IDLE;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                    BASE: begin
                        // o_wcount counts list registers only, so it is left alone here
                        we_q       <= 1'b1;
                        waddr_q    <= baseAddr_q;
                        baseUpd_q  <= 1'b1;
                        busy_q     <= 1'b0;
                        basePend_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_we       = we_q;
    assign o_waddr    = waddr_q;
    assign o_busy     = busy_q;
    assign o_wcount   = wcount_q;
    assign o_base_upd = BASE_EN ? baseUpd_q : 1'b0;

endmodule

// File: tb/tb_wb_seq_ctrl.sv
// tb_wb_seq_ctrl: directed self-checking bench for wb_seq_ctrl in its default
// build (WB_BASE_UPD_EN undefined, so o_base_upd is expected to stay 0).
module tb_wb_seq_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] i_ir_wb;
    logic        i_valid;
    logic        i_stall;
    logic        o_we;
    logic [3:0]  o_waddr;
    logic        o_busy;
    logic [4:0]  o_wcount;
    logic        o_base_upd;

    int assertCount = 0;
    int failCount   = 0;

    wb_seq_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .i_ir_wb    (i_ir_wb),
        .i_valid    (i_valid),
        .i_stall    (i_stall),
        .o_we       (o_we),
        .o_waddr    (o_waddr),
        .o_busy     (o_busy),
        .o_wcount   (o_wcount),
        .o_base_upd (o_base_upd)
    );

    // Free-running clock, 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs, then settle just past the edge that consumes them.
    task automatic applyStimulus(input logic [15:0] ir, input logic valid, input logic stall);
        i_ir_wb = ir;
        i_valid = valid;
        i_stall = stall;
        @(posedge clk);
        #1;
    endtask

    // Compare every output against the hand-computed expectation for this step.
    task automatic checkOutput(input string tag, input logic expWe, input logic [3:0] expAddr,
                               input logic expBusy, input logic [4:0] expCount);
        assertCount++;
        assert (o_we === expWe) else begin
            failCount++;
            $error("FAIL %s o_we: observed %0b expected %0b", tag, o_we, expWe);
        end
        assertCount++;
        assert (o_waddr === expAddr) else begin
            failCount++;
            $error("FAIL %s o_waddr: observed %0d expected %0d", tag, o_waddr, expAddr);
        end
        assertCount++;
        assert (o_busy === expBusy) else begin
            failCount++;
            $error("FAIL %s o_busy: observed %0b expected %0b", tag, o_busy, expBusy);
        end
        assertCount++;
        assert (o_wcount === expCount) else begin
            failCount++;
            $error("FAIL %s o_wcount: observed %0d expected %0d", tag, o_wcount, expCount);
        end
        assertCount++;
        assert (o_base_upd === 1'b0) else begin
            failCount++;
            $error("FAIL %s o_base_upd: observed %0b expected 0", tag, o_base_upd);
        end
    endtask

    // Linear directed sequence.
    initial begin
        rst     = 1'b1;
        i_ir_wb = 16'h0000;
        i_valid = 1'b0;
        i_stall = 1'b0;
        applyStimulus(16'h18CB, 1'b1, 1'b0);
        applyStimulus(16'h18CB, 1'b1, 1'b0);
        checkOutput("reset", 1'b0, 4'd0, 1'b0, 5'd0);
        rst = 1'b0;

        // single-write decode
        applyStimulus(16'h18CB, 1'b1, 1'b0);
        checkOutput("add_r3", 1'b1, 4'd3, 1'b0, 5'd0);
        applyStimulus(16'h2905, 1'b1, 1'b0);
        checkOutput("cmp_nowrite", 1'b0, 4'd3, 1'b0, 5'd0);
        applyStimulus(16'h4691, 1'b1, 1'b0);
        checkOutput("mov_hi_r9", 1'b1, 4'd9, 1'b0, 5'd0);
        applyStimulus(16'hB002, 1'b1, 1'b0);
        checkOutput("add_sp", 1'b1, 4'd13, 1'b0, 5'd0);
        applyStimulus(16'h0055, 1'b1, 1'b0);
        checkOutput("lsl_r5", 1'b1, 4'd5, 1'b0, 5'd0);
        applyStimulus(16'h2601, 1'b1, 1'b0);
        checkOutput("mov_imm_r6", 1'b1, 4'd6, 1'b0, 5'd0);
        applyStimulus(16'h6814, 1'b1, 1'b0);
        checkOutput("ldr_r4", 1'b1, 4'd4, 1'b0, 5'd0);
        applyStimulus(16'h18CB, 1'b0, 1'b0);
        checkOutput("not_valid", 1'b0, 4'd4, 1'b0, 5'd0);
        applyStimulus(16'h18CB, 1'b1, 1'b1);
        checkOutput("idle_stall", 1'b0, 4'd4, 1'b0, 5'd0);
        applyStimulus(16'hE000, 1'b1, 1'b0);
        checkOutput("branch_nowrite", 1'b0, 4'd4, 1'b0, 5'd0);

        // POP {r0,r2,pc} with valid pulses during busy
        applyStimulus(16'hBD05, 1'b1, 1'b0);
        checkOutput("pop_w0", 1'b1, 4'd0, 1'b1, 5'd1);
        applyStimulus(16'h18CB, 1'b1, 1'b0);
        checkOutput("pop_w2", 1'b1, 4'd2, 1'b1, 5'd2);
        applyStimulus(16'h2601, 1'b1, 1'b0);
        checkOutput("pop_wpc", 1'b1, 4'd15, 1'b0, 5'd3);
        applyStimulus(16'h0000, 1'b0, 1'b0);
        checkOutput("pop_done", 1'b0, 4'd15, 1'b0, 5'd3);
        applyStimulus(16'h18CB, 1'b1, 1'b0);
        checkOutput("single_keeps_count", 1'b1, 4'd3, 1'b0, 5'd3);

        // POP {r1,r4} with a stall in the middle
        applyStimulus(16'hBC12, 1'b1, 1'b0);
        checkOutput("pop2_w1", 1'b1, 4'd1, 1'b1, 5'd1);
        applyStimulus(16'h18CB, 1'b1, 1'b1);
        checkOutput("pop2_stall", 1'b0, 4'd1, 1'b1, 5'd1);
        applyStimulus(16'h0000, 1'b0, 1'b0);
        checkOutput("pop2_w4", 1'b1, 4'd4, 1'b0, 5'd2);
        applyStimulus(16'h0000, 1'b0, 1'b0);
        checkOutput("pop2_done", 1'b0, 4'd4, 1'b0, 5'd2);

        // empty-mask POP
        applyStimulus(16'hBC00, 1'b1, 1'b0);
        checkOutput("pop_empty", 1'b0, 4'd4, 1'b0, 5'd0);

        // reset in the middle of LDMIA r2!,{r0-r7}
        applyStimulus(16'hCAFF, 1'b1, 1'b0);
        checkOutput("ldm_w0", 1'b1, 4'd0, 1'b1, 5'd1);
        applyStimulus(16'h0000, 1'b0, 1'b0);
        checkOutput("ldm_w1", 1'b1, 4'd1, 1'b1, 5'd2);
        rst = 1'b1;
        applyStimulus(16'h0000, 1'b0, 1'b0);
        checkOutput("ldm_reset", 1'b0, 4'd0, 1'b0, 5'd0);
        rst = 1'b0;
        applyStimulus(16'h0000, 1'b0, 1'b0);
        checkOutput("ldm_abandoned", 1'b0, 4'd0, 1'b0, 5'd0);

        // LDMIA {r6,r7}; accept on the cycle busy drops
        applyStimulus(16'hC8C0, 1'b1, 1'b0);
        checkOutput("ldm2_w6", 1'b1, 4'd6, 1'b1, 5'd1);
        applyStimulus(16'h18CB, 1'b1, 1'b0);
        checkOutput("ldm2_w7", 1'b1, 4'd7, 1'b0, 5'd2);
        applyStimulus(16'h2601, 1'b1, 1'b0);
        checkOutput("accept_after_busy", 1'b1, 4'd6, 1'b0, 5'd2);

        // single-bit LDMIA {r3}: no busy at all
        applyStimulus(16'hC808, 1'b1, 1'b0);
        checkOutput("ldm_single", 1'b1, 4'd3, 1'b0, 5'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
